// File: rtl/alu_rr_sched_if.sv
// Request/response bundle between the two client FSMs, the shared-ALU
// scheduler and the result consumer.
interface alu_rr_sched_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;

  // Client/consumer side: drives requests and takes results.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU between two requesters.
//
// state | meaning
// IDLE  | arbitrating; the granted requester is accepted this cycle
// EXEC  | ALU evaluates the captured operands
// RESP  | result held on the response channel until the consumer takes it
module alu_rr_sched #(
  parameter int WIDTH      = 4,
  parameter bit FIRST_PRIO = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_rr_sched_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             grant;
  logic             grant_vld;
  logic             accept;
  logic             rsp_fire;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_res;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic             rsp_zero_q;
  logic [WIDTH-1:0] rsp_data_q;

  // Arbitration: a lone requester wins, a contested grant goes to the one not served last.
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      grant = ~last_grant;
    else
      grant = bus.req1_valid;
  end

  assign accept   = (state == IDLE) && grant_vld;
  assign rsp_fire = (state == RESP) && bus.rsp_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? EXEC : IDLE;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = bus.rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; ready is a pure function of state and the request valids.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    busy           = (state != IDLE);
    if (accept) begin
      bus.req0_ready = ~grant;
      bus.req1_ready = grant;
    end
  end

  // Capture the winning operation so requesters are free after the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= ~FIRST_PRIO;
    end else if (accept) begin
      id_q       <= grant;
      last_grant <= grant;
      if (grant) begin
        op_q <= bus.req1_op;
        a_q  <= bus.req1_a;
        b_q  <= bus.req1_b;
      end else begin
        op_q <= bus.req0_op;
        a_q  <= bus.req0_a;
        b_q  <= bus.req0_b;
      end
    end
  end

  // Shared ALU on the captured operands; all results unsigned and truncated.
  always_comb begin
    alu_res = '0;
    case (op_q)
      3'b000: alu_res = a_q + b_q;
      3'b001: alu_res = a_q - b_q;
      3'b010: alu_res = ~(a_q & b_q);
      3'b011: alu_res = ~(a_q | b_q);
      3'b100: alu_res = (a_q < b_q) ? WIDTH'(1) : '0;
      3'b101: alu_res = (a_q == b_q) ? WIDTH'(1) : '0;
      3'b110: alu_res = a_q << b_q[SH_W-1:0];
      3'b111: alu_res = a_q >> b_q[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // Response register: loaded at the end of EXEC, released on the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      done_cnt    <= '0;
    end else if (state == EXEC) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= id_q;
      rsp_data_q  <= alu_res;
      rsp_zero_q  <= (alu_res == '0);
    end else if (rsp_fire) begin
      rsp_valid_q <= 1'b0;
      done_cnt    <= done_cnt + CNT_W'(1);
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
endmodule
